// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle for one side of a pipeline stage boundary.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a two-entry skid buffer, synchronous flush to a
// bubble value, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = {32'hfffffffc, 32'h00000001},
    parameter int               CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    pipe_stage_reg_if.slave        up_i,
    pipe_stage_reg_if.master       dn_o,
    output logic [1:0]             occupancy_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q;
    logic             accept;
    logic             emit;

    // in_ready depends only on registered state, so out_ready never reaches it.
    assign up_i.ready  = (state_q != FULL);
    assign dn_o.valid  = (state_q != EMPTY);
    assign dn_o.data   = main_q;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_q;

    assign accept = up_i.valid & up_i.ready;
    assign emit   = dn_o.valid & dn_o.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = up_i.data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = up_i.data;
                    end else if (accept) begin
                        skid_d  = up_i.data;
                        state_d = FULL;
                    end else if (emit) begin
                        main_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (dn_o.valid && !dn_o.ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stimulus process queues accepted
// payloads and a separate monitor compares every cycle against that FIFO model.
module tb_pipe_stage_reg;

    localparam int          WIDTH  = 64;
    localparam int          CNT_W  = 3;
    localparam logic [63:0] BUBBLE = 64'hfffffffc_00000001;
    localparam int          SATMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stallCnt;

    logic [63:0]      expQ[$];
    int               stallModel;
    int               compCount = 0;
    int               failCount = 0;

    pipe_stage_reg_if #(.WIDTH(WIDTH)) upIf ();
    pipe_stage_reg_if #(.WIDTH(WIDTH)) dnIf ();

    pipe_stage_reg #(
        .WIDTH (WIDTH),
        .BUBBLE(BUBBLE),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .up_i       (upIf),
        .dn_o       (dnIf),
        .occupancy_o(occupancy),
        .stall_cnt_o(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle; the accepted payload enters the model just after the edge.
    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
        logic willAccept;
        @(negedge clk);
        upIf.valid = v;
        upIf.data  = d;
        dnIf.ready = ordy;
        flush      = fl;
        willAccept = v && (expQ.size() < 2) && !rst;
        @(posedge clk);
        #1;
        if (willAccept && !fl) expQ.push_back(d);
    endtask

    task automatic asyncReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        stallModel = 0;
        #1;
        checkOutput("rstOutValid", {63'b0, dnIf.valid}, 64'd0);
        checkOutput("rstInReady", {63'b0, upIf.ready}, 64'd1);
        checkOutput("rstOccupancy", {62'b0, occupancy}, 64'd0);
        checkOutput("rstOutData", dnIf.data, BUBBLE);
        checkOutput("rstStallCnt", {{(64-CNT_W){1'b0}}, stallCnt}, 64'd0);
        @(negedge clk);
        upIf.valid = 1'b0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    // Monitor: sample just before each rising edge, then retire emitted entries.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                checkOutput("rstHoldValid", {63'b0, dnIf.valid}, 64'd0);
                checkOutput("rstHoldData", dnIf.data, BUBBLE);
            end else begin
                checkOutput("outValid", {63'b0, dnIf.valid}, {63'b0, expQ.size() != 0});
                checkOutput("inReady", {63'b0, upIf.ready}, {63'b0, expQ.size() < 2});
                checkOutput("occupancy", {62'b0, occupancy}, 64'(expQ.size()));
                checkOutput("outData", dnIf.data, (expQ.size() != 0) ? expQ[0] : BUBBLE);
                checkOutput("stallCnt", {{(64-CNT_W){1'b0}}, stallCnt}, 64'(stallModel));
                if (expQ.size() != 0 && !dnIf.ready && stallModel < SATMAX) stallModel++;
                if (expQ.size() != 0 && dnIf.ready) void'(expQ.pop_front());
                if (flush) expQ.delete();
            end
        end
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        upIf.valid = 1'b0;
        upIf.data  = '0;
        dnIf.ready = 1'b0;
        stallModel = 0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Streaming at full rate
        applyStimulus(1'b1, 64'h10, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h12, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Backpressure into the skid entry, then drain
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hB, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hBAD, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Flush colliding with an emit while full
        asyncReset();
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hB, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Flush discarding a same-cycle accept
        applyStimulus(1'b1, 64'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hD, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Stall counter saturation survives flush, cleared by reset
        asyncReset();
        applyStimulus(1'b1, 64'hE, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        asyncReset();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        repeat (3) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that replaces the fixed per-stage registers driven by a 2-bit update code.
- Carries an arbitrary WIDTH payload between two pipeline stages using valid/ready handshakes.
- Contains a 2-entry skid buffer, so `in_ready` is a pure function of registered state and full throughput is sustained.
- Supports synchronous flush to a parametrised bubble value, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 64, payload width in bits (≥1).
- BUBBLE, {32'hfffffffc, 32'h00000001}, payload value loaded on reset/flush and driven when empty; WIDTH bits.
- CNT_W, 16, width of the stall counter (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; registered-state function only, no combinational path from `out_ready`.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  `out_data` holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  head payload; equals BUBBLE when empty.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

Behaviour:
- Storage: registers `main` (head) and `skid`; state EMPTY(0), ONE(1), FULL(2); `occupancy` equals the state encoding.
- Definitions: `accept` = `in_valid` & `in_ready`; `emit` = `out_valid` & `out_ready`.
- Combinational outputs:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
  - `out_data` = `main`.
- Reset (asynchronous, rst=1): state=EMPTY, `main`=`skid`=BUBBLE, `stall_cnt`=0. Outputs are therefore `in_ready`=1, `out_valid`=0, `out_data`=BUBBLE, `occupancy`=0.
- Reset mid-transfer: any in-flight data is lost; no handshake completes in a cycle where rst is asserted.
- Transitions (flush=0):
  - EMPTY: `accept` → `main`<=in_data, go to ONE. Otherwise hold.
  - ONE, `accept` & `emit` → `main`<=in_data, stay ONE (one payload per cycle throughput).
  - ONE, `accept` & !`emit` → `skid`<=in_data, go to FULL.
  - ONE, !`accept` & `emit` → `main`<=BUBBLE, go to EMPTY.
  - ONE, neither → hold.
  - FULL: `emit` → `main`<=`skid`, `skid`<=BUBBLE, go to ONE. Otherwise hold. `accept` is impossible in FULL.
- Ordering: strict FIFO; payloads leave in acceptance order; no payload is duplicated or dropped except by flush or rst.
- Latency: an accepted payload appears on `out_data` the cycle after acceptance when the stage was EMPTY, or when it was ONE with a simultaneous emit.
- Flush (synchronous, priority over all transitions):
  - Next state=EMPTY, `main`=`skid`=BUBBLE.
  - A same-cycle `accept` is discarded; upstream treats flush as also killing its own transfer.
  - A same-cycle `emit` still counts as delivered, because the downstream sampled `out_data` that cycle.
- `stall_cnt`:
  - Increments by 1 each cycle with `out_valid` & !`out_ready`, saturating at 2^CNT_W−1 with no wrap.
  - Unaffected by flush; cleared only by rst.
- Data values are never interpreted; no arithmetic on the payload.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=64'hfffffffc_00000001 immediately, without waiting for a clock edge.
- Streaming: `out_ready`=1, send 0x10,0x11,0x12 on consecutive cycles → `out_data` shows 0x10,0x11,0x12 on the next three cycles; `occupancy` stays 1; `in_ready` stays 1.
- Backpressure/skid: `out_ready`=0, send 0xA then 0xB → `occupancy`=2, `in_ready`=0, `out_data`=0xA, `stall_cnt` increments each stalled cycle. Then raise `out_ready` → 0xA then 0xB are emitted; state goes to EMPTY.
- Flush with collision: FULL with 0xA/0xB, assert flush together with `out_ready`=1 → 0xA counts as delivered; next cycle `occupancy`=0 and `out_data`=BUBBLE; 0xB is never emitted.
- Flush vs accept: ONE holding 0xC, `in_valid`=1 data 0xD, flush=1 → next cycle EMPTY; 0xD never appears on `out_data`.
- Counter saturation: CNT_W=3, hold `out_valid`=1 with `out_ready`=0 for 10 cycles → `stall_cnt`=7 and stays at 7; flush leaves it at 7; rst clears it to 0.
